// File: rtl/sd_seq_pkg.sv
// rtl/sd_seq_pkg.sv - shared types and defaults for the sd sequence generator/checker pair
package sd_seq_pkg;

  typedef enum logic [1:0] {
    ST_WAIT,
    ST_SYNC,
    ST_CHECK
  } seq_state_t;

  // Replicated across pat_dep bits, so the default pattern is "always ready".
  localparam logic DEF_PAT_FILL    = 1'b1;
  localparam int   DEF_STARTUP_CYC = 10;

endpackage

// File: rtl/sd_pat_ptr.sv
// rtl/sd_pat_ptr.sv - wrapping pattern pointer with next-slot bit select
module sd_pat_ptr #(
  parameter int                 pat_dep = 8,
  parameter logic [pat_dep-1:0] pat     = '1
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clear,
  input  logic advance,
  output logic pat_bit
);

  localparam int PW = (pat_dep > 1) ? $clog2(pat_dep) : 1;

  logic [PW-1:0] ptr;
  logic [PW-1:0] ptr_nxt;

  always_comb begin
    ptr_nxt = ptr;
    if (clear) begin
      ptr_nxt = '0;
    end else if (advance) begin
      ptr_nxt = (ptr == PW'(pat_dep - 1)) ? '0 : ptr + PW'(1);
    end
  end

  // The bit for the slot being entered, so the caller can register it alongside ptr.
  assign pat_bit = pat[ptr_nxt];

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      ptr <= '0;
    end else begin
      ptr <= ptr_nxt;
    end
  end

endmodule

// File: rtl/sd_seq_check.sv
// rtl/sd_seq_check.sv - srdy/drdy consumer that checks a +1 data sequence and handshake rules
module sd_seq_check
  import sd_seq_pkg::*;
#(
  parameter int                 width       = 8,
  parameter int                 pat_dep     = 8,
  parameter logic [pat_dep-1:0] drdy_pat    = {pat_dep{DEF_PAT_FILL}},
  parameter int                 startup_cyc = DEF_STARTUP_CYC,
  parameter int                 cnt_width   = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 c_srdy,
  output logic                 c_drdy,
  input  logic [width-1:0]     c_data,
  output logic [cnt_width-1:0] xfer_cnt,
  output logic [cnt_width-1:0] ok_cnt,
  output logic [cnt_width-1:0] err_cnt,
  output logic                 err,
  output logic                 proto_err,
  output logic [width-1:0]     expected
);

  localparam int SW = (startup_cyc > 0) ? $clog2(startup_cyc + 1) : 1;

  seq_state_t     state, state_nxt;
  logic [SW-1:0]  start_cnt;
  logic           go_sync;
  logic           xfer;
  logic           pat_bit;
  logic           drdy_nxt;
  logic           p_stall;
  logic [width-1:0] p_data;

  assign go_sync = (state == ST_WAIT) && (start_cnt == SW'(startup_cyc));
  assign xfer    = c_srdy && c_drdy;

  sd_pat_ptr #(
    .pat_dep (pat_dep),
    .pat     (drdy_pat)
  ) u_pat_ptr (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (go_sync),
    .advance (state != ST_WAIT),
    .pat_bit (pat_bit)
  );

  always_comb begin
    state_nxt = state;
    drdy_nxt  = 1'b0;
    case (state)
      ST_WAIT: begin
        if (go_sync) begin
          state_nxt = ST_SYNC;
          drdy_nxt  = pat_bit;
        end
      end
      ST_SYNC: begin
        drdy_nxt = pat_bit;
        if (xfer) state_nxt = ST_CHECK;
      end
      ST_CHECK: drdy_nxt = pat_bit;
      default:  state_nxt = ST_WAIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state     <= ST_WAIT;
      start_cnt <= '0;
      c_drdy    <= 1'b0;
      p_stall   <= 1'b0;
      p_data    <= '0;
      xfer_cnt  <= '0;
      ok_cnt    <= '0;
      err_cnt   <= '0;
      err       <= 1'b0;
      proto_err <= 1'b0;
      expected  <= '0;
    end else begin
      state   <= state_nxt;
      c_drdy  <= drdy_nxt;
      p_stall <= c_srdy && !c_drdy;
      p_data  <= c_data;
      if (state == ST_WAIT && !go_sync) start_cnt <= start_cnt + SW'(1);
      // A stalled producer must hold valid and data until accepted.
      if (state != ST_WAIT && p_stall && (!c_srdy || c_data != p_data)) proto_err <= 1'b1;
      if (xfer && state != ST_WAIT) begin
        expected <= c_data + width'(1);
        if (xfer_cnt != '1) xfer_cnt <= xfer_cnt + cnt_width'(1);
        if (state == ST_CHECK) begin
          if (c_data == expected) begin
            if (ok_cnt != '1) ok_cnt <= ok_cnt + cnt_width'(1);
          end else begin
            if (err_cnt != '1) err_cnt <= err_cnt + cnt_width'(1);
            err <= 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_sd_seq_check.sv
// tb/tb_sd_seq_check.sv - directed bench for sd_seq_check
module tb_sd_seq_check;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        c_srdy = 1'b0;
  logic [7:0]  c_data = '0;
  logic        c_srdy2 = 1'b0;
  logic [7:0]  c_data2 = '0;

  logic        c_drdy1, err1, proto1;
  logic [15:0] xfer1, ok1, errc1;
  logic [7:0]  exp1;
  logic        c_drdy2, err2, proto2;
  logic [15:0] xfer2, ok2, errc2;
  logic [7:0]  exp2;
  logic        c_drdy3, err3, proto3;
  logic [1:0]  xfer3, ok3, errc3;
  logic [7:0]  exp3;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  sd_seq_check dut1 (
    .clk(clk), .reset_n(reset_n), .c_srdy(c_srdy), .c_drdy(c_drdy1), .c_data(c_data),
    .xfer_cnt(xfer1), .ok_cnt(ok1), .err_cnt(errc1), .err(err1), .proto_err(proto1),
    .expected(exp1)
  );

  sd_seq_check #(.drdy_pat(8'b0000_0101)) dut2 (
    .clk(clk), .reset_n(reset_n), .c_srdy(c_srdy2), .c_drdy(c_drdy2), .c_data(c_data2),
    .xfer_cnt(xfer2), .ok_cnt(ok2), .err_cnt(errc2), .err(err2), .proto_err(proto2),
    .expected(exp2)
  );

  sd_seq_check #(.cnt_width(2)) dut3 (
    .clk(clk), .reset_n(reset_n), .c_srdy(c_srdy), .c_drdy(c_drdy3), .c_data(c_data),
    .xfer_cnt(xfer3), .ok_cnt(ok3), .err_cnt(errc3), .err(err3), .proto_err(proto3),
    .expected(exp3)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_chk++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, got, want);
  endtask

  // Leaves reset asserted across one edge; caller releases it.
  task automatic hold_reset();
    @(negedge clk);
    reset_n = 1'b0;
    c_srdy  = 1'b0;
    c_srdy2 = 1'b0;
    @(negedge clk);
  endtask

  task automatic send(input logic [7:0] v);
    int n;
    n = 0;
    c_srdy = 1'b1;
    c_data = v;
    while (!c_drdy1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) check("send_timeout", n, 0);
    @(negedge clk);
  endtask

  task automatic idle(input int cyc);
    c_srdy = 1'b0;
    repeat (cyc) @(negedge clk);
  endtask

  logic       last_d, d;
  logic [7:0] pat_exp;

  initial begin
    // Test 1: reset state, startup delay, 1..20 back-to-back
    hold_reset();
    check("rst_drdy", c_drdy1, 0);
    check("rst_xfer", xfer1, 0);
    check("rst_exp", exp1, 0);
    check("rst_err", err1, 0);
    reset_n = 1'b1;
    repeat (10) @(negedge clk);
    check("t1_drdy_low", c_drdy1, 0);
    @(negedge clk);
    check("t1_drdy_high", c_drdy1, 1);
    for (int v = 1; v <= 20; v++) send(8'(v));
    idle(2);
    check("t1_xfer", xfer1, 20);
    check("t1_ok", ok1, 19);
    check("t1_errc", errc1, 0);
    check("t1_err", err1, 0);
    check("t1_exp", exp1, 21);
    check("t1_proto", proto1, 0);
    check("t1_sat_xfer", xfer3, 3);
    check("t1_sat_ok", ok3, 3);
    check("t1_sat_exp", exp3, 21);

    // Test 2: gap in sequence and resync
    hold_reset();
    reset_n = 1'b1;
    send(8'd1); send(8'd2); send(8'd3); send(8'd5);
    check("t2_errc_at5", errc1, 1);
    check("t2_err_at5", err1, 1);
    check("t2_exp_at5", exp1, 6);
    send(8'd6); send(8'd7);
    idle(2);
    check("t2_ok", ok1, 4);
    check("t2_exp", exp1, 8);
    check("t2_xfer", xfer1, 6);
    check("t2_sat_errc", errc3, 1);
    check("t2_sat_ok", ok3, 3);

    // Test 3: modular wrap
    hold_reset();
    reset_n = 1'b1;
    send(8'd253); send(8'd254); send(8'd255); send(8'd0); send(8'd1);
    idle(2);
    check("t3_errc", errc1, 0);
    check("t3_ok", ok1, 4);
    check("t3_exp", exp1, 2);

    // Test 4: drdy pattern 0000_0101 with producer always valid
    hold_reset();
    reset_n = 1'b1;
    c_srdy2 = 1'b1;
    c_data2 = 8'd0;
    pat_exp = 8'b0000_0101;
    last_d  = 1'b0;
    repeat (10) @(negedge clk);
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (last_d) c_data2 = c_data2 + 8'd1;
      d = c_drdy2;
      check($sformatf("t4_slot%0d", i), d, pat_exp[i % 8]);
      last_d = d;
    end
    @(negedge clk);
    check("t4_xfer", xfer2, 4);
    check("t4_ok", ok2, 3);
    check("t4_exp", exp2, 4);
    check("t4_proto", proto2, 0);

    // Test 5: producer drops valid while stalled
    hold_reset();
    reset_n = 1'b1;
    repeat (11) @(negedge clk);
    @(negedge clk);
    check("t5_drdy_slot1", c_drdy2, 0);
    c_srdy2 = 1'b1;
    c_data2 = 8'd7;
    @(negedge clk);
    check("t5_proto_before", proto2, 0);
    c_srdy2 = 1'b0;
    @(negedge clk);
    check("t5_proto", proto2, 1);
    check("t5_err", err2, 0);

    // Test 6: reset mid-CHECK discards a coincident beat
    hold_reset();
    reset_n = 1'b1;
    for (int v = 1; v <= 6; v++) send(8'(v));
    check("t6_ok_pre", ok1, 5);
    c_srdy  = 1'b1;
    c_data  = 8'd7;
    reset_n = 1'b0;
    @(negedge clk);
    check("t6_rst_xfer", xfer1, 0);
    check("t6_rst_ok", ok1, 0);
    check("t6_rst_exp", exp1, 0);
    check("t6_rst_drdy", c_drdy1, 0);
    reset_n = 1'b1;
    c_srdy  = 1'b0;
    repeat (10) @(negedge clk);
    check("t6_drdy_low", c_drdy1, 0);
    @(negedge clk);
    check("t6_drdy_high", c_drdy1, 1);
    send(8'd20); send(8'd21);
    idle(2);
    check("t6_err", err1, 0);
    check("t6_errc", errc1, 0);
    check("t6_ok", ok1, 1);
    check("t6_xfer", xfer1, 2);
    check("t6_exp", exp1, 22);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/sd_seq_check.md
# sd_seq_check

Srdy/drdy sequence checker for testbenches. It is the consumer-side counterpart to the incrementing-sequence traffic generator. It drives c_drdy according to a programmable backpressure pattern, and it checks that accepted data forms a +1 sequence modulo 2^width. It also monitors producer handshake rules. It sits at the output of a block under test and reports error and progress counters to the bench.

## Interface
- width, default 8: data bus width.
- pat_dep, default 8: depth of the drdy pattern, in bits.
- drdy_pat, default all ones: backpressure pattern, pat_dep bits. Bit i drives c_drdy in pattern slot i.
- startup_cyc, default 10: cycles after reset release during which c_drdy is held at 0.
- cnt_width, default 16: width of the status counters.
- clk  input  1  clock; all logic is on the rising edge.
- reset_n  input  1  synchronous, active-low reset.
- c_srdy  input  1  producer valid.
- c_drdy  output  1  consumer ready, registered.
- c_data  input  width  producer data.
- xfer_cnt  output  cnt_width  number of accepted transfers; saturating.
- ok_cnt  output  cnt_width  number of in-sequence transfers; saturating.
- err_cnt  output  cnt_width  number of sequence mismatches; saturating.
- err  output  1  sticky; set on the first mismatch.
- proto_err  output  1  sticky; set on a producer handshake violation.
- expected  output  width  next data value the checker expects.

## Operation
- A transfer occurs when c_srdy and c_drdy are both 1 at a rising edge.
- **States:**
  - WAIT: count startup_cyc cycles with c_drdy=0, then go to SYNC.
  - SYNC: the first transfer loads expected=c_data+1 and increments xfer_cnt only; no compare is made. Go to CHECK.
  - CHECK: on each transfer, compare c_data with expected.
    - Match: ok_cnt++, expected++.
    - Mismatch: err_cnt++, err<=1, expected<=c_data+1 (resync).
    - xfer_cnt++ in both cases.
- **drdy pattern:**
  - Pointer ptr is cleared on the WAIT→SYNC edge, and c_drdy<=drdy_pat[0] on that same edge.
  - In SYNC and CHECK, ptr<=(ptr+1)%pat_dep every cycle, and c_drdy<=drdy_pat[next ptr].
  - The pointer advances whether or not a transfer occurs.
- **Protocol check (SYNC/CHECK only):** proto_err<=1 if the previous cycle had c_srdy=1 and c_drdy=0, and the current cycle has c_srdy=0 or c_data changed.
- **Arithmetic:** expected is computed modulo 2^width, so 2^width-1 followed by 0 is a match. The counters stick at all ones.

## Timing
- Reset values: c_drdy=0, all counters 0, err=0, proto_err=0, expected=0, state WAIT, startup counter 0, ptr 0.
- Reset has priority. reset_n=0 at an edge discards any coincident transfer and returns every output to its reset value on that edge. WAIT restarts after reset_n returns high.
- First possible c_drdy=1: the edge startup_cyc cycles after the first edge with reset_n=1.
- Counter and expected updates appear one edge after the transfer edge, with no further latency.
- Simultaneous mismatch and protocol violation: both sticky flags set on the same edge.
- A counter saturated at all ones keeps the other counters updating normally.

## Structure
- Shared package sd_seq_pkg holds:
  - the state enum (WAIT, SYNC, CHECK);
  - the default pattern constant;
  - the default startup_cyc.
- The package is also used by the generator.
- One natural sub-module, sd_pat_ptr. It contains the pattern pointer and the slot-select logic, and is reusable by the generator for srdy patterns.
- The checker FSM, comparator and counters stay in sd_seq_check.

## Test plan
1. Default pattern; producer sends 1..20 back-to-back after reset → c_drdy rises after 10 cycles; xfer_cnt=20, ok_cnt=19, err_cnt=0, err=0, expected=21.
2. Sequence 1,2,3,5,6,7 → err_cnt=1 and err=1 after the beat with value 5; expected resyncs to 6; final ok_cnt=4 and expected=8.
3. width=8, sequence 253,254,255,0,1 → err_cnt=0, ok_cnt=4, expected=2.
4. drdy_pat=8'b0000_0101, producer always valid → c_drdy pattern 1,0,1,0,0,0,0,0, repeating every 8 cycles; 2 transfers per 8 cycles.
5. Producer asserts c_srdy with data 7 while c_drdy=0, then deasserts c_srdy next cycle → proto_err=1; err stays 0.
6. reset_n=0 for one cycle mid-CHECK with counters at 5 → all outputs 0 on that edge; c_drdy held 0 for 10 more cycles; the next first beat resyncs with no error.
